mdu_e: RTL

- Multiply/divide unit in the execute stage of the P7 pipeline.
- Consumes the E-stage register outputs (operands RD1/RD2 after forwarding, decoded op) and owns the architectural HI/LO registers.
- Produces `busy` for the hazard unit, which freezes MD-class instructions in D.
- Supplies HI/LO read data for MFHI/MFLO towards the E→M register.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_e_if.sv | 25 ++
 rtl/mdu_calc.sv | 49 ++++
 rtl/mdu_e.sv | 90 +++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encoding, widths and default latencies.
package mdu_pkg;

    localparam int MD_OP_W          = 4;
    localparam int MULT_CYCLES_DEF  = 5;
    localparam int DIV_CYCLES_DEF   = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // Multi-cycle ops are the ones that raise busy and commit through temp.
    function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_e_if.sv
// E-stage <-> MDU signal bundle. Handshake: an op is accepted at a rising
// edge when start=1, Req=0 and busy=0; otherwise start is ignored.
interface mdu_e_if;

    logic                         Req;
    logic                         start;
    logic [mdu_pkg::MD_OP_W-1:0]  md_op;
    logic [31:0]                  A;
    logic [31:0]                  B;
    logic                         busy;
    logic [31:0]                  HI_o;
    logic [31:0]                  LO_o;
    logic [31:0]                  MD_out;

    modport master (
        output Req, start, md_op, A, B,
        input  busy, HI_o, LO_o, MD_out
    );

    modport slave (
        input  Req, start, md_op, A, B,
        output busy, HI_o, LO_o, MD_out
    );

endinterface

// File: rtl/mdu_calc.sv
// Combinational result generator for MULT/MULTU/DIV/DIVU; the result is
// captured by mdu_e at launch and committed when the countdown ends.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo,
    output logic               div_by_zero
);

    always_comb begin
        res_hi      = '0;
        res_lo      = '0;
        div_by_zero = 1'b0;
        case (md_op)
            MD_MULT: begin
                {res_hi, res_lo} = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
            end
            MD_MULTU: begin
                {res_hi, res_lo} = {32'b0, A} * {32'b0, B};
            end
            MD_DIV: begin
                if (B == 32'd0) begin
                    div_by_zero = 1'b1;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    // The one overflowing signed quotient wraps to itself.
                    res_lo = A;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(A) / $signed(B);
                    res_hi = $signed(A) % $signed(B);
                end
            end
            MD_DIVU: begin
                if (B == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: owns HI/LO, models a fixed
// multi-cycle latency with a down-counter, and serves MFHI/MFLO reads.
module mdu_e
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_e_if.slave md
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      temp_hi_q;
    logic [31:0]      temp_lo_q;
    logic             temp_dz_q;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_by_zero;
    logic             accept;

    mdu_calc u_calc (
        .md_op       (md.md_op),
        .A           (md.A),
        .B           (md.B),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    // A flushed instruction (Req) or one arriving while busy never takes effect.
    assign accept = md.start && !md.Req && !busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            temp_hi_q <= '0;
            temp_lo_q <= '0;
            temp_dz_q <= 1'b0;
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                if (!temp_dz_q) begin
                    hi_q <= temp_hi_q;
                    lo_q <= temp_lo_q;
                end
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end else if (accept) begin
            if (is_long_op(md.md_op)) begin
                temp_hi_q <= res_hi;
                temp_lo_q <= res_lo;
                temp_dz_q <= div_by_zero;
                cnt_q     <= is_div_op(md.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy_q    <= 1'b1;
            end else if (md.md_op == MD_MTHI) begin
                hi_q <= md.A;
            end else if (md.md_op == MD_MTLO) begin
                lo_q <= md.A;
            end
        end
    end

    always_comb begin
        md.MD_out = '0;
        if (md.md_op == MD_MFHI) begin
            md.MD_out = hi_q;
        end else if (md.md_op == MD_MFLO) begin
            md.MD_out = lo_q;
        end
    end

    assign md.busy = busy_q;
    assign md.HI_o = hi_q;
    assign md.LO_o = lo_q;

endmodule
